cache_controller: RTL and testbench
===================================

// Module: cache_controller
// PURPOSE
//  Sequencer for the 4-line, 16-bit cache datapath: direct-mapped, write-through, no-write-allocate.
//  Holds tag/valid arrays and takes one CPU request at a time. Drives the cache ports.
//  On a miss it fetches from main memory over a req/ack handshake. Sits between CPU and cache+memory.
// PARAMETERS
//  DATA_W  16          data width; matches cache data ports
//  ADDR_W  8           CPU/memory word-address width
//  INDEX_W 2           cache index width (4 lines); TAG_W = ADDR_W-INDEX_W
// PORTS
//  clk                input  1        single clock, rising edge
//  rst                input  1        asynchronous, active-low reset
//  cpu_req            input  1        request strobe; sampled only in IDLE
//  cpu_we             input  1        1=write, 0=read
//  cpu_addr           input  ADDR_W   word address
//  cpu_wdata          input  DATA_W   write data
//  cpu_busy           output 1        high in every state except IDLE
//  cpu_done           output 1        1-cycle pulse: request complete
//  cpu_rdata          output DATA_W   read data; valid with cpu_done on reads, then held
//  enable_read_cache  output 1        to cache
//  enable_write_cache output 1        to cache
//  addr_cache         output INDEX_W  to cache
//  data_in_cache      output DATA_W   to cache
//  data_out_cache     input  DATA_W   from cache; valid 1 cycle after enable_read_cache
//  mem_req            output 1        memory request; held until mem_ack
//  mem_we             output 1        memory write qualifier
//  mem_addr           output ADDR_W   memory address
//  mem_wdata          output DATA_W   memory write data
//  mem_ack            input  1        1-cycle completion pulse from memory
//  mem_rdata          input  DATA_W   read data; valid with mem_ack
// BEHAVIOUR
//  Reset (async, rst=0): state=IDLE; all valid bits=0; all outputs 0, including cpu_rdata.
//  Requests are latched (addr/we/wdata) on an IDLE cycle with cpu_req=1; index=addr[INDEX_W-1:0], tag=upper bits.
//  FSM: IDLE -> TAG_CHK -> {RD_WAIT | MEM_RD -> FILL | MEM_WR} -> IDLE.
//  TAG_CHK: hit = valid[idx] && tag_arr[idx]==tag.
//   - read hit: enable_read_cache=1 with addr_cache=idx; go to RD_WAIT.
//   - read miss: go to MEM_RD.
//   - write hit: enable_write_cache=1 with data_in_cache=wdata; go to MEM_WR.
//   - write miss: go to MEM_WR; cache untouched.
//  RD_WAIT: capture data_out_cache into cpu_rdata; cpu_done=1 next cycle (IDLE).
//  MEM_RD: mem_req=1, mem_we=0, mem_addr=latched addr. On mem_ack: capture mem_rdata, go to FILL.
//  FILL: enable_write_cache=1 with data_in_cache=captured data; tag_arr[idx]<=tag, valid[idx]<=1.
//   cpu_rdata=captured data; cpu_done=1 next cycle (IDLE).
//  MEM_WR: mem_req=1, mem_we=1, mem_wdata=wdata. On mem_ack: cpu_done=1 next cycle (IDLE).
//  Latency req->done: read hit 3 cycles; read miss 3+N; write 2+N (N = cycles mem_req high, >=1).
//  mem_req/mem_we/mem_addr/mem_wdata are stable while mem_req=1; mem_req is low the cycle after ack.
//  enable_read_cache and enable_write_cache are never high together; each is high for exactly 1 cycle.
//  cpu_req while cpu_busy=1: ignored, not queued. mem_ack outside MEM_RD/MEM_WR: ignored.
//  cpu_req is accepted in the same cycle cpu_done pulses (state is IDLE then).
//  Reset mid-operation: transaction is aborted, no cpu_done, mem_req drops immediately, all lines invalid.
//  Conflicting tag at the same index: the fill overwrites the line (no victim write-back; write-through).
// CONFIGURATION
//  CACHE_STATS_EN defined: adds outputs hit_count and miss_count, each 16 bits.
//   Each is incremented in TAG_CHK for reads and writes, saturates at 16'hFFFF, and resets to 0.
//  CACHE_STATS_EN undefined: no counters; both ports are absent.
// TESTING
//  1 Reset, then read 0x15 -> miss: mem_req, mem_addr=0x15; ack with 0xBEEF -> line 1 filled, cpu_rdata=0xBEEF.
//  2 Read 0x15 again -> hit: no mem_req; cpu_done 3 cycles after req, cpu_rdata=0xBEEF.
//  3 Write 0x15=0x1234 -> cache line 1 written and mem write 0x15/0x1234; a following read hits with 0x1234.
//  4 Write 0x22=0xAAAA (miss) -> mem write only, no enable_write_cache; read 0x22 then misses.
//  5 Read 0x25 (same index as 0x15) -> miss, refill; then read 0x15 misses (line evicted).
//  6 Assert rst during MEM_RD with mem_ack held off -> mem_req=0 at once, no cpu_done, next read 0x15 misses.

Source files
------------

// File: rtl/cache_controller.sv
// cache_controller: sequencer for a 4-line direct-mapped, write-through, no-write-allocate cache.
// Define CACHE_STATS_EN to add saturating 16-bit hit_count/miss_count outputs.
module cache_controller #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 8,
    parameter int INDEX_W = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cpu_req,
    input  logic               cpu_we,
    input  logic [ADDR_W-1:0]  cpu_addr,
    input  logic [DATA_W-1:0]  cpu_wdata,
    output logic               cpu_busy,
    output logic               cpu_done,
    output logic [DATA_W-1:0]  cpu_rdata,
    output logic               enable_read_cache,
    output logic               enable_write_cache,
    output logic [INDEX_W-1:0] addr_cache,
    output logic [DATA_W-1:0]  data_in_cache,
    input  logic [DATA_W-1:0]  data_out_cache,
    output logic               mem_req,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic               mem_ack,
    input  logic [DATA_W-1:0]  mem_rdata,
    output logic [2:0]         state_dbg
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0]        hit_count,
    output logic [15:0]        miss_count
`endif
);
    localparam int TAG_W = ADDR_W - INDEX_W;
    localparam int LINES = 1 << INDEX_W;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        TAG_CHK = 3'd1,
        RD_WAIT = 3'd2,
        MEM_RD  = 3'd3,
        FILL    = 3'd4,
        MEM_WR  = 3'd5
    } state_t;

    state_t             state, state_next;
    logic [ADDR_W-1:0]  addr_q;
    logic               we_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [DATA_W-1:0]  fill_q;
    logic [TAG_W-1:0]   tag_arr [LINES];
    logic [LINES-1:0]   valid;
    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag;
    logic               hit;
    logic               done_next;

    assign idx       = addr_q[INDEX_W-1:0];
    assign tag       = addr_q[ADDR_W-1:INDEX_W];
    assign hit       = valid[idx] && (tag_arr[idx] == tag);
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // Memory-side outputs are decoded from state only, so reset drops mem_req immediately.
    always_comb begin
        state_next         = state;
        cpu_busy           = (state != IDLE);
        enable_read_cache  = 1'b0;
        enable_write_cache = 1'b0;
        addr_cache         = '0;
        data_in_cache      = '0;
        mem_req            = 1'b0;
        mem_we             = 1'b0;
        mem_addr           = '0;
        mem_wdata          = '0;
        done_next          = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_req) state_next = TAG_CHK;
            end
            TAG_CHK: begin
                if (we_q) begin
                    if (hit) begin
                        enable_write_cache = 1'b1;
                        addr_cache         = idx;
                        data_in_cache      = wdata_q;
                    end
                    state_next = MEM_WR;
                end else if (hit) begin
                    enable_read_cache = 1'b1;
                    addr_cache        = idx;
                    state_next        = RD_WAIT;
                end else begin
                    state_next = MEM_RD;
                end
            end
            RD_WAIT: begin
                done_next  = 1'b1;
                state_next = IDLE;
            end
            MEM_RD: begin
                mem_req  = 1'b1;
                mem_addr = addr_q;
                if (mem_ack) state_next = FILL;
            end
            FILL: begin
                enable_write_cache = 1'b1;
                addr_cache         = idx;
                data_in_cache      = fill_q;
                done_next          = 1'b1;
                state_next         = IDLE;
            end
            MEM_WR: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                if (mem_ack) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            fill_q    <= '0;
            valid     <= '0;
            cpu_done  <= 1'b0;
            cpu_rdata <= '0;
            for (int i = 0; i < LINES; i++) tag_arr[i] <= '0;
        end else begin
            cpu_done <= done_next;
            if (state == IDLE && cpu_req) begin
                addr_q  <= cpu_addr;
                we_q    <= cpu_we;
                wdata_q <= cpu_wdata;
            end
            if (state == MEM_RD && mem_ack) fill_q <= mem_rdata;
            if (state == RD_WAIT) cpu_rdata <= data_out_cache;
            if (state == FILL) begin
                cpu_rdata    <= fill_q;
                tag_arr[idx] <= tag;
                valid[idx]   <= 1'b1;
            end
        end
    end

`ifdef CACHE_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == TAG_CHK) begin
            if (hit && hit_count != 16'hFFFF)        hit_count  <= hit_count + 16'd1;
            else if (!hit && miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench for cache_controller: directed scenarios plus randomized traffic
// checked against a line-level model of a direct-mapped write-through cache.
module tb_cache_controller;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [7:0]  cpu_addr = '0;
    logic [15:0] cpu_wdata = '0;
    logic        cpu_busy, cpu_done;
    logic [15:0] cpu_rdata;
    logic        enable_read_cache, enable_write_cache;
    logic [1:0]  addr_cache;
    logic [15:0] data_in_cache;
    logic [15:0] data_out_cache = '0;
    logic        mem_req, mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic [2:0]  state_dbg;
`ifdef CACHE_STATS_EN
    logic [15:0] hit_count, miss_count;
    int          exp_hits = 0, exp_misses = 0;
`endif

    int checks = 0;
    int errors = 0;

    // Environment: cache data RAM and main memory contents
    logic [15:0] cram [4];
    logic [15:0] mem_arr [256];

    // Reference model: which full address each line holds, and its data
    bit          mv [4];
    logic [7:0]  maddr [4];
    logic [15:0] mdata [4];
    logic [15:0] last_rdata = '0;
    logic [15:0] exp_q [$];

    cache_controller dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_busy(cpu_busy), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
        .enable_read_cache(enable_read_cache), .enable_write_cache(enable_write_cache),
        .addr_cache(addr_cache), .data_in_cache(data_in_cache), .data_out_cache(data_out_cache),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .state_dbg(state_dbg)
`ifdef CACHE_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (enable_write_cache) cram[addr_cache] <= data_in_cache;
        if (enable_read_cache)  data_out_cache   <= cram[addr_cache];
    end

    task automatic clear_model();
        for (int i = 0; i < 4; i++) mv[i] = 1'b0;
        last_rdata = '0;
`ifdef CACHE_STATS_EN
        exp_hits = 0;
        exp_misses = 0;
`endif
    endtask

    // One CPU transaction; memory answers after n cycles of mem_req. now=1 issues in the current cycle.
    task automatic txn(input logic we, input logic [7:0] addr, input logic [15:0] wd, input int n, input bit now);
        int cycles = 0, req_cyc = 0, wr_seen = 0, rd_seen = 0, both = 0, exp_lat;
        bit saw_mem = 0, unstable = 0, hit, exp_mem;
        logic [7:0] m_addr = '0;
        logic m_we = 1'b0;
        logic [15:0] m_wd = '0, exp_rd;
        logic [1:0] idx;
        idx = addr[1:0];
        hit = mv[idx] && (maddr[idx] == addr);
        if (!we) exp_q.push_back(hit ? mdata[idx] : mem_arr[addr]);
        if (!now) @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        @(negedge clk);
        cycles = 1;
        while (!cpu_done && cycles < 100) begin
            if (mem_req) begin
                if (!saw_mem) begin
                    m_addr = mem_addr; m_we = mem_we; m_wd = mem_wdata;
                end else if (mem_addr !== m_addr || mem_we !== m_we || mem_wdata !== m_wd) begin
                    unstable = 1;
                end
                saw_mem = 1;
                req_cyc++;
            end
            if (mem_req && req_cyc == n) begin
                mem_ack = 1'b1;
                mem_rdata = mem_arr[mem_addr];
                if (mem_we) mem_arr[mem_addr] = mem_wdata;
            end else begin
                mem_rdata = 16'($urandom);
            end
            if (enable_write_cache) wr_seen++;
            if (enable_read_cache) rd_seen++;
            if (enable_write_cache && enable_read_cache) both++;
            // Junk requests while busy must be ignored
            cpu_req = 1'($urandom_range(0, 1)); cpu_we = 1'($urandom_range(0, 1));
            cpu_addr = 8'($urandom); cpu_wdata = 16'($urandom);
            @(negedge clk);
            mem_ack = 1'b0;
            cycles++;
        end
        cpu_req = 1'b0;
        exp_mem = we || !hit;
        exp_lat = we ? 2 + n : (hit ? 3 : 3 + n);
        checks++; if (cpu_done !== 1'b1) begin errors++; $display("FAIL done_timeout addr=%h: no cpu_done in %0d cycles", addr, cycles); end
        checks++; if (cycles != exp_lat) begin errors++; $display("FAIL latency addr=%h we=%0b: got %0d want %0d", addr, we, cycles, exp_lat); end
        checks++; if (cpu_busy !== 1'b0) begin errors++; $display("FAIL busy_at_done: got %0b want 0", cpu_busy); end
        checks++; if (req_cyc != (exp_mem ? n : 0)) begin errors++; $display("FAIL mem_req_cycles addr=%h: got %0d want %0d", addr, req_cyc, exp_mem ? n : 0); end
        if (exp_mem) begin
            checks++; if (m_addr !== addr || m_we !== we) begin errors++; $display("FAIL mem_cmd: got addr=%h we=%0b want addr=%h we=%0b", m_addr, m_we, addr, we); end
            if (we) begin
                checks++; if (m_wd !== wd) begin errors++; $display("FAIL mem_wdata: got %h want %h", m_wd, wd); end
            end
        end
        checks++; if (unstable || both != 0) begin errors++; $display("FAIL protocol: unstable=%0b overlap=%0d want 0/0", unstable, both); end
        checks++; if (wr_seen != ((we ? hit : !hit) ? 1 : 0) || rd_seen != ((!we && hit) ? 1 : 0)) begin
            errors++; $display("FAIL cache_enables addr=%h: wr=%0d rd=%0d want wr=%0d rd=%0d", addr, wr_seen, rd_seen,
                               (we ? hit : !hit) ? 1 : 0, (!we && hit) ? 1 : 0);
        end
        if (!we) begin
            exp_rd = exp_q.pop_front();
            checks++; if (cpu_rdata !== exp_rd) begin errors++; $display("FAIL rdata addr=%h: got %h want %h", addr, cpu_rdata, exp_rd); end
            last_rdata = exp_rd;
            if (!hit) begin mv[idx] = 1'b1; maddr[idx] = addr; mdata[idx] = exp_rd; end
        end else begin
            checks++; if (cpu_rdata !== last_rdata) begin errors++; $display("FAIL rdata_hold: got %h want %h", cpu_rdata, last_rdata); end
            if (hit) mdata[idx] = wd;
        end
`ifdef CACHE_STATS_EN
        if (hit) exp_hits++; else exp_misses++;
        checks++; if (hit_count !== 16'(exp_hits) || miss_count !== 16'(exp_misses)) begin
            errors++; $display("FAIL stats: got %0d/%0d want %0d/%0d", hit_count, miss_count, exp_hits, exp_misses);
        end
`endif
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if ({cpu_busy, cpu_done, cpu_rdata, enable_read_cache, enable_write_cache, addr_cache,
                      data_in_cache, mem_req, mem_we, mem_addr, mem_wdata, state_dbg} !== '0) begin
            errors++; $display("FAIL reset_outputs: busy=%0b done=%0b rdata=%h mem_req=%0b state=%0d want all 0",
                               cpu_busy, cpu_done, cpu_rdata, mem_req, state_dbg);
        end
        rst = 1'b1;
        @(negedge clk);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        checks++; if (cpu_busy !== 1'b0 || cpu_done !== 1'b0 || mem_req !== 1'b0) begin
            errors++; $display("FAIL idle_ack_ignored: busy=%0b done=%0b mem_req=%0b want 0", cpu_busy, cpu_done, mem_req);
        end
    endtask

    task automatic test_read_miss_fill();
        mem_arr[8'h15] = 16'hBEEF;
        txn(1'b0, 8'h15, 16'h0, 2, 1'b0);
        checks++; if (cram[1] !== 16'hBEEF) begin errors++; $display("FAIL fill_line1: got %h want beef", cram[1]); end
    endtask

    task automatic test_read_hit();
        txn(1'b0, 8'h15, 16'h0, 1, 1'b0);
    endtask

    task automatic test_write_hit();
        txn(1'b1, 8'h15, 16'h1234, 3, 1'b0);
        checks++; if (mem_arr[8'h15] !== 16'h1234) begin errors++; $display("FAIL mem_written: got %h want 1234", mem_arr[8'h15]); end
        txn(1'b0, 8'h15, 16'h0, 1, 1'b0);
    endtask

    task automatic test_write_miss();
        txn(1'b1, 8'h22, 16'hAAAA, 1, 1'b0);
        txn(1'b0, 8'h22, 16'h0, 2, 1'b0);
    endtask

    task automatic test_conflict_evict();
        mem_arr[8'h25] = 16'h5A5A;
        txn(1'b0, 8'h25, 16'h0, 1, 1'b0);
        txn(1'b0, 8'h15, 16'h0, 2, 1'b0);
    endtask

    task automatic test_back_to_back();
        txn(1'b0, 8'h15, 16'h0, 1, 1'b0);
        txn(1'b0, 8'h25, 16'h0, 1, 1'b1);
        txn(1'b1, 8'h15, 16'h7777, 1, 1'b1);
    endtask

    task automatic test_reset_mid_op();
        bit done_seen = 0;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h15;
        @(negedge clk);
        cpu_req = 1'b0;
        for (int c = 0; c < 5 && !mem_req; c++) @(negedge clk);
        @(negedge clk);
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL mem_rd_pending: mem_req=%0b want 1", mem_req); end
        rst = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0 || cpu_busy !== 1'b0 || cpu_rdata !== 16'h0) begin
            errors++; $display("FAIL async_abort: mem_req=%0b busy=%0b rdata=%h want 0/0/0", mem_req, cpu_busy, cpu_rdata);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (cpu_done) done_seen = 1;
        end
        rst = 1'b1;
        clear_model();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (cpu_done) done_seen = 1;
        end
        checks++; if (done_seen) begin errors++; $display("FAIL aborted_done: cpu_done seen=1 want 0"); end
        txn(1'b0, 8'h15, 16'h0, 2, 1'b0);
    endtask

    task automatic test_random();
        logic [7:0] a;
        for (int i = 0; i < 60; i++) begin
            a = 8'({$urandom_range(0, 2), 6'd0} | 8'($urandom_range(0, 3)));
            a = {a[7:6], 4'h0, a[1:0]};
            txn(1'($urandom_range(0, 1)), a, 16'($urandom), $urandom_range(1, 4), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem_arr[i] = 16'($urandom);
        for (int i = 0; i < 4; i++) cram[i] = '0;
        clear_model();
        test_reset();
        test_read_miss_fill();
        test_read_hit();
        test_write_hit();
        test_write_miss();
        test_conflict_evict();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end
endmodule
